// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate generator with 2-entry skid buffer
// Optional macro IMM_ZICSR_EN: SYSTEM CSR*I instructions report fmt Z with the zero-extended uimm.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  logic [31:0]      dec_imm32;
  fmt_e             dec_fmt;
  logic             dec_illegal;
  logic [XLEN-1:0]  dec_imm;

  always_comb begin
    dec_imm32   = 32'd0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b1110011: begin
`ifdef IMM_ZICSR_EN
        if (in_instr[14]) begin
          dec_fmt   = FMT_Z;
          dec_imm32 = {27'd0, in_instr[19:15]};
        end else begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
`else
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_instr[31:12], 12'd0};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // The Z immediate has bit 31 clear, so one sign extension covers every format.
  assign dec_imm = XLEN'($signed(dec_imm32));

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;

  logic accept;
  logic load_out;
  logic to_skid;
  logic skid_valid_next;

  assign accept   = in_valid & in_ready;
  assign load_out = ~out_valid | out_ready;
  assign to_skid  = accept & ~load_out;

  always_comb begin
    skid_valid_next = skid_valid;
    if (load_out)
      skid_valid_next = 1'b0;
    else if (to_skid)
      skid_valid_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_fmt      <= 3'd0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= 3'd0;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else begin
      in_ready   <= ~skid_valid_next;
      skid_valid <= skid_valid_next;
      if (load_out) begin
        out_valid <= skid_valid | accept;
        // in_ready is low whenever skid holds data, so skid and accept never compete.
        if (skid_valid) begin
          out_imm     <= skid_imm;
          out_fmt     <= skid_fmt;
          out_illegal <= skid_illegal;
          out_tag     <= skid_tag;
        end else if (accept) begin
          out_imm     <= dec_imm;
          out_fmt     <= dec_fmt;
          out_illegal <= dec_illegal;
          out_tag     <= in_tag;
        end
      end
      if (to_skid) begin
        skid_imm     <= dec_imm;
        skid_fmt     <= dec_fmt;
        skid_illegal <= dec_illegal;
        skid_tag     <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe, XLEN=32 and XLEN=64 side by side
// Build with +define+IMM_ZICSR_EN to exercise the CSR uimm format.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [3:0]  in_tag = 4'd0;
  logic        out_ready = 1'b0;

  logic        rdy32, v32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [3:0]  tag32;
  logic        rdy64, v64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [3:0]  tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [3:0]  tag;
  } exp_t;

  exp_t       q[$];
  logic [3:0] delivered[$];
  int         checks = 0;
  int         failures = 0;
  int         n_acc = 0;

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference decode: immediates built as signed integer arithmetic on instruction fields.
  function automatic exp_t model(logic [31:0] i, logic [3:0] t);
    exp_t e;
    int   v;
    int   sgn;
    int   fmt;
    sgn = i[31] ? -1 : 0;
    v   = 0;
    fmt = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h1B: begin fmt = 1; v = int'($signed(i)) >>> 20; end
      7'h73: begin
`ifdef IMM_ZICSR_EN
        if (i[14]) begin fmt = 6; v = int'(i[19:15]); end
        else begin fmt = 1; v = int'($signed(i)) >>> 20; end
`else
        fmt = 1; v = int'($signed(i)) >>> 20;
`endif
      end
      7'h23: begin fmt = 2; v = (int'($signed(i)) >>> 25) * 32 + int'(i[11:7]); end
      7'h63: begin fmt = 3; v = sgn * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2; end
      7'h6F: begin fmt = 5; v = sgn * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2; end
      7'h37, 7'h17: begin fmt = 4; v = int'(i & 32'hFFFFF000); end
      default: begin fmt = 0; v = 0; end
    endcase
    e.fmt64 = 3'(fmt);
    e.ill64 = (fmt == 0);
    e.imm64 = 64'(longint'(v));
    if (i[6:0] == 7'h1B) begin
      e.fmt32 = 3'd0; e.ill32 = 1'b1; e.imm32 = 32'd0;
    end else begin
      e.fmt32 = 3'(fmt); e.ill32 = (fmt == 0); e.imm32 = 32'(v);
    end
    e.tag = t;
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [6:0]  ops [0:10];
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  // One clock: update the FIFO model with the handshakes seen before the edge, then compare.
  task automatic cyc();
    bit acc, drn;
    acc = in_valid && rdy32;
    drn = v32 && out_ready;
    if (drn) begin
      delivered.push_back(tag32);
      void'(q.pop_front());
    end
    if (acc) begin
      q.push_back(model(in_instr, in_tag));
      n_acc++;
    end
    @(posedge clk);
    #1;
    chk("out_valid32", v32, q.size() > 0);
    chk("out_valid64", v64, q.size() > 0);
    chk("in_ready32", rdy32, q.size() < 2);
    chk("in_ready64", rdy64, q.size() < 2);
    if (q.size() > 0) begin
      chk("imm32", imm32, q[0].imm32);
      chk("fmt32", fmt32, q[0].fmt32);
      chk("ill32", ill32, q[0].ill32);
      chk("tag32", tag32, q[0].tag);
      chk("imm64", imm64, q[0].imm64);
      chk("fmt64", fmt64, q[0].fmt64);
      chk("ill64", ill64, q[0].ill64);
      chk("tag64", tag64, q[0].tag);
    end
  endtask

  task automatic dsend(string name, logic [31:0] ins, logic [3:0] t,
                       logic [31:0] e32, logic [2:0] f32, logic i32,
                       logic [63:0] e64, logic [2:0] f64, logic i64);
    in_valid = 1'b1; in_instr = ins; in_tag = t;
    chk({name, "_ready"}, rdy32, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk({name, "_valid"}, v32, 1'b1);
    chk({name, "_imm32"}, imm32, e32);
    chk({name, "_fmt32"}, fmt32, f32);
    chk({name, "_ill32"}, ill32, i32);
    chk({name, "_imm64"}, imm64, e64);
    chk({name, "_fmt64"}, fmt64, f64);
    chk({name, "_ill64"}, ill64, i64);
    chk({name, "_tag"}, tag32, t);
    cyc();
  endtask

  initial begin
    int d0;
    int a0;
    bit hit;
    @(posedge clk);
    #1;
    chk("rst_out_valid", v32, 1'b0);
    chk("rst_out_imm", imm64, 64'd0);
    chk("rst_out_fmt", fmt32, 3'd0);
    chk("rst_out_ill", ill32, 1'b0);
    chk("rst_out_tag", tag32, 4'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk("post_rst_in_ready", rdy32, 1'b1);

    dsend("addi", 32'hFFF00093, 4'd1, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    dsend("sw",   32'hFE112E23, 4'd2, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    dsend("beq",  32'hFE000CE3, 4'd3, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    dsend("lui",  32'h800000B7, 4'd4, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    dsend("addiw", 32'h0010009B, 4'd5, 32'd0, 3'd0, 1'b1, 64'd1, 3'd1, 1'b0);
`ifdef IMM_ZICSR_EN
    dsend("csrrwi", 32'h3002D0F3, 4'd6, 32'd5, 3'd6, 1'b0, 64'd5, 3'd6, 1'b0);
`else
    dsend("csrrwi", 32'h3002D0F3, 4'd6, 32'h300, 3'd1, 1'b0, 64'h300, 3'd1, 1'b0);
`endif
    dsend("bad_op", 32'h0000007F, 4'd7, 32'd0, 3'd0, 1'b1, 64'd0, 3'd0, 1'b1);

    // Backpressure: two accepted, third held off, then drained in order.
    delivered.delete();
    a0 = n_acc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = rnd_instr(); in_tag = 4'd1; cyc();
    in_instr = rnd_instr(); in_tag = 4'd2; cyc();
    in_instr = rnd_instr(); in_tag = 4'd3; cyc(); cyc(); cyc();
    chk("bp_accepted", n_acc - a0, 2);
    chk("bp_in_ready", rdy32, 1'b0);
    chk("bp_hold_tag", tag32, 4'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      hit = in_valid && rdy32;
      cyc();
      if (hit) in_valid = 1'b0;
      if (!in_valid && q.size() == 0) break;
    end
    chk("bp_in_valid_done", in_valid, 1'b0);
    chk("bp_count", delivered.size(), 3);
    for (int k = 0; k < 3 && k < delivered.size(); k++)
      chk("bp_order", delivered[k], 4'(k + 1));
    chk("bp_in_ready_back", rdy32, 1'b1);

    // Throughput: one result per cycle with out_ready held high.
    d0 = delivered.size();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_instr = rnd_instr(); in_tag = 4'(k);
      chk("tp_in_ready", rdy32, 1'b1);
      cyc();
      chk("tp_out_valid", v32, 1'b1);
    end
    in_valid = 1'b0;
    cyc();
    chk("tp_count", delivered.size() - d0, 8);

    // Reset with both entries full: held results vanish at once.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = rnd_instr(); in_tag = 4'd9; cyc();
    in_instr = rnd_instr(); in_tag = 4'd10; cyc();
    in_valid = 1'b0;
    chk("mr_full", rdy32, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", v32, 1'b0);
    chk("mr_out_imm", imm64, 64'd0);
    chk("mr_out_fmt", fmt64, 3'd0);
    chk("mr_out_ill", ill32, 1'b0);
    chk("mr_out_tag", tag32, 4'd0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    delivered.delete();
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("mr_no_replay", delivered.size(), 0);

    // Randomized traffic against the FIFO model.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = rnd_instr();
      in_tag    = 4'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    chk("final_drained", v32, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
